// File: rtl/placement_pkg.sv
// ---------------------------------------------------------------------------
// placement_pkg
// Shared definitions for the placement flow (placer FSM and cost evaluator).
//   pce_state_t : state encoding of the wire-cost evaluator walk
//   NO_POS      : coordinate value marking an unplaced node
//   sat_add     : unsigned add that clamps at 2^w-1 instead of wrapping
//   in_grid     : true when (x,y) lies on a gw x gh grid
// ---------------------------------------------------------------------------
package placement_pkg;

    typedef enum logic [3:0] {
        IDLE,
        E_RD,
        E_WT,
        A_RD,
        A_WT,
        B_RD,
        B_WT,
        B_CAP,
        DIFF,
        ACC,
        DONE
    } pce_state_t;

    localparam int NO_POS = -1;

    // Operands are carried at 64 bits so one function serves every
    // accumulator width; the caller truncates the result back to w bits.
    function automatic logic [63:0] sat_add(input logic [63:0] acc,
                                            input logic [63:0] inc,
                                            input int          w);
        logic [64:0] sum;
        logic [64:0] lim;
        sum = {1'b0, acc} + {1'b0, inc};
        lim = (65'd1 << w) - 65'd1;
        return (sum > lim) ? lim[63:0] : sum[63:0];
    endfunction

    function automatic logic in_grid(input logic signed [31:0] x,
                                     input logic signed [31:0] y,
                                     input int                 gw,
                                     input int                 gh);
        return (x >= 0) && (x < gw) && (y >= 0) && (y < gh);
    endfunction

endpackage

// File: rtl/placement_cost_eval_hop_cost.sv
// ---------------------------------------------------------------------------
// hop_cost
// Registered edge-cost datapath. On load it captures |ax-bx|, |ay-by| and the
// edge validity; the cost outputs are derived from those registers so they
// are stable in the cycle after load.
//   clk, reset       : clock, synchronous active-low reset
//   load             : capture the current endpoint coordinates
//   ax, ay, bx, by   : signed endpoint coordinates
//   hop_log2         : hop length exponent k (hop length 2^k)
//   valid            : edge counts toward the cost
//   c_man            : dx+dy-1
//   c_hop            : ceil(dx/2^k)+ceil(dy/2^k)-1
// ---------------------------------------------------------------------------
module hop_cost
    import placement_pkg::*;
#(
    parameter int COORD_W = 16,
    parameter int GRID_W  = 7,
    parameter int GRID_H  = 7,
    parameter int HOP_LW  = 3
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      load,
    input  logic signed [COORD_W-1:0] ax,
    input  logic signed [COORD_W-1:0] ay,
    input  logic signed [COORD_W-1:0] bx,
    input  logic signed [COORD_W-1:0] by,
    input  logic        [HOP_LW-1:0]  hop_log2,
    output logic                      valid,
    output logic        [COORD_W+1:0] c_man,
    output logic        [COORD_W+1:0] c_hop
);

    localparam int DW = COORD_W + 1;

    logic signed [DW-1:0] sx;
    logic signed [DW-1:0] sy;
    logic        [DW-1:0] dxc;
    logic        [DW-1:0] dyc;
    logic                 validc;
    logic        [DW-1:0] dxr;
    logic        [DW-1:0] dyr;
    logic                 validr;

    // Differences are taken one bit wider than the coordinates so the full
    // signed range cannot overflow before the absolute value is taken.
    always_comb begin
        sx     = {ax[COORD_W-1], ax} - {bx[COORD_W-1], bx};
        sy     = {ay[COORD_W-1], ay} - {by[COORD_W-1], by};
        dxc    = sx[DW-1] ? DW'(-sx) : DW'(sx);
        dyc    = sy[DW-1] ? DW'(-sy) : DW'(sy);
        validc = 1'b1;
        if ((32'(ax) == NO_POS) || (32'(ay) == NO_POS) ||
            (32'(bx) == NO_POS) || (32'(by) == NO_POS))
            validc = 1'b0;
        if (!in_grid(32'(ax), 32'(ay), GRID_W, GRID_H) ||
            !in_grid(32'(bx), 32'(by), GRID_W, GRID_H))
            validc = 1'b0;
        if ((ax == bx) && (ay == by))
            validc = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            dxr    <= '0;
            dyr    <= '0;
            validr <= 1'b0;
        end else if (load) begin
            dxr    <= dxc;
            dyr    <= dyc;
            validr <= validc;
        end
    end

    logic [DW:0] dxe;
    logic [DW:0] dye;
    logic [DW:0] round_add;
    logic [DW:0] ceil_x;
    logic [DW:0] ceil_y;

    // A valid edge always has dx+dy >= 1, so the -1 terms cannot underflow;
    // invalid edges report zero cost so the outputs never show garbage.
    always_comb begin
        dxe       = {1'b0, dxr};
        dye       = {1'b0, dyr};
        round_add = ((DW+1)'(1) << hop_log2) - (DW+1)'(1);
        ceil_x    = (dxe + round_add) >> hop_log2;
        ceil_y    = (dye + round_add) >> hop_log2;
        valid     = validr;
        c_man     = '0;
        c_hop     = '0;
        if (validr) begin
            c_man = dxe + dye - (DW+1)'(1);
            c_hop = ceil_x + ceil_y - (DW+1)'(1);
        end
    end

endmodule

// File: rtl/placement_cost_eval.sv
// ---------------------------------------------------------------------------
// placement_cost_eval
// Walks the edge list, fetches both endpoint positions and accumulates the
// Manhattan cost, the 2^k-hop cost and the worst single-edge cost.
//   clk, reset            : clock, synchronous active-low reset
//   start, abort          : run request (IDLE only) / return to IDLE
//   n_edge, hop_log2      : edge count and hop exponent, latched at start
//   re_edge, addr_edge    : shared read port of the A/B endpoint ROMs
//   din_ea, din_eb        : endpoint node indices
//   re_pos, addr_pos      : shared read port of the X/Y position RAMs
//   din_px, din_py        : node coordinates
//   busy, done            : run in progress / one-cycle completion pulse
//   sum_man, sum_hop      : saturating cost sums
//   max_cost, invalid_cnt : worst edge cost / excluded edge count
// ---------------------------------------------------------------------------
module placement_cost_eval
    import placement_pkg::*;
#(
    parameter int EDGE_AW = 6,
    parameter int NODE_AW = 6,
    parameter int COORD_W = 16,
    parameter int GRID_W  = 7,
    parameter int GRID_H  = 7,
    parameter int ACC_W   = 32,
    parameter int HOP_LW  = 3
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      abort,
    input  logic        [EDGE_AW:0]   n_edge,
    input  logic        [HOP_LW-1:0]  hop_log2,
    output logic                      re_edge,
    output logic        [EDGE_AW-1:0] addr_edge,
    input  logic        [NODE_AW-1:0] din_ea,
    input  logic        [NODE_AW-1:0] din_eb,
    output logic                      re_pos,
    output logic        [NODE_AW-1:0] addr_pos,
    input  logic signed [COORD_W-1:0] din_px,
    input  logic signed [COORD_W-1:0] din_py,
    output logic                      busy,
    output logic                      done,
    output logic        [ACC_W-1:0]   sum_man,
    output logic        [ACC_W-1:0]   sum_hop,
    output logic        [ACC_W-1:0]   max_cost,
    output logic        [EDGE_AW:0]   invalid_cnt
);

    pce_state_t state;
    pce_state_t next_state;

    logic        [EDGE_AW:0]   idx;
    logic        [EDGE_AW:0]   n_lat;
    logic        [HOP_LW-1:0]  hop_lat;
    logic        [NODE_AW-1:0] eb;
    logic signed [COORD_W-1:0] ax;
    logic signed [COORD_W-1:0] ay;
    logic signed [COORD_W-1:0] bx;
    logic signed [COORD_W-1:0] by;

    logic                      edge_valid;
    logic        [COORD_W+1:0] c_man;
    logic        [COORD_W+1:0] c_hop;
    logic        [ACC_W-1:0]   c_man_sat;

    logic accept;
    assign accept = (state == IDLE) && start && !abort;

    always_ff @(posedge clk) begin
        if (!reset)
            state <= IDLE;
        else
            state <= next_state;
    end

    // Each edge is a fixed nine-state walk; abort wins from any busy state.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept) next_state = (n_edge == '0) ? DONE : E_RD;
            E_RD:    next_state = E_WT;
            E_WT:    next_state = A_RD;
            A_RD:    next_state = A_WT;
            A_WT:    next_state = B_RD;
            B_RD:    next_state = B_WT;
            B_WT:    next_state = B_CAP;
            B_CAP:   next_state = DIFF;
            DIFF:    next_state = ACC;
            ACC:     next_state = ((idx + 1'b1) == n_lat) ? DONE : E_RD;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
        if (abort && (state != IDLE))
            next_state = IDLE;
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    hop_cost #(
        .COORD_W (COORD_W),
        .GRID_W  (GRID_W),
        .GRID_H  (GRID_H),
        .HOP_LW  (HOP_LW)
    ) u_hop_cost (
        .clk      (clk),
        .reset    (reset),
        .load     (state == DIFF),
        .ax       (ax),
        .ay       (ay),
        .bx       (bx),
        .by       (by),
        .hop_log2 (hop_lat),
        .valid    (edge_valid),
        .c_man    (c_man),
        .c_hop    (c_hop)
    );

    // The worst-edge register uses the same clamp as the sums so a single
    // edge wider than the accumulator still reads as all-ones.
    assign c_man_sat = ACC_W'(sat_add(64'd0, 64'(c_man), ACC_W));

    // Read strobes are single-cycle; the memory data appears two states after
    // the issuing state, which is where the matching capture happens. The
    // A-side position read is addressed straight from the ROM data because
    // the endpoint has not been registered yet in that cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            re_edge     <= 1'b0;
            addr_edge   <= '0;
            re_pos      <= 1'b0;
            addr_pos    <= '0;
            idx         <= '0;
            n_lat       <= '0;
            hop_lat     <= '0;
            eb          <= '0;
            ax          <= '0;
            ay          <= '0;
            bx          <= '0;
            by          <= '0;
            sum_man     <= '0;
            sum_hop     <= '0;
            max_cost    <= '0;
            invalid_cnt <= '0;
        end else begin
            re_edge <= 1'b0;
            re_pos  <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        n_lat       <= n_edge;
                        hop_lat     <= hop_log2;
                        idx         <= '0;
                        sum_man     <= '0;
                        sum_hop     <= '0;
                        max_cost    <= '0;
                        invalid_cnt <= '0;
                    end
                end
                E_RD: begin
                    re_edge   <= 1'b1;
                    addr_edge <= idx[EDGE_AW-1:0];
                end
                A_RD: begin
                    eb       <= din_eb;
                    re_pos   <= 1'b1;
                    addr_pos <= din_ea;
                end
                B_RD: begin
                    ax       <= din_px;
                    ay       <= din_py;
                    re_pos   <= 1'b1;
                    addr_pos <= eb;
                end
                B_CAP: begin
                    bx <= din_px;
                    by <= din_py;
                end
                ACC: begin
                    idx <= idx + 1'b1;
                    if (edge_valid) begin
                        sum_man <= ACC_W'(sat_add(64'(sum_man), 64'(c_man), ACC_W));
                        sum_hop <= ACC_W'(sat_add(64'(sum_hop), 64'(c_hop), ACC_W));
                        if (c_man_sat > max_cost)
                            max_cost <= c_man_sat;
                    end else begin
                        invalid_cnt <= invalid_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_placement_cost_eval.sv
// ---------------------------------------------------------------------------
// tb_placement_cost_eval
// Scoreboard bench for placement_cost_eval. Two instances share stimulus:
// one with the default 32-bit accumulators and one with 4-bit accumulators
// to exercise saturation. Expected results come from a plain arithmetic
// model of the cost rules and are queued when a run is started; a monitor
// pops and compares them whenever a done pulse appears.
// ---------------------------------------------------------------------------
module tb_placement_cost_eval;

    localparam int EAW = 6;
    localparam int NAW = 6;
    localparam int CW  = 16;
    localparam int GW  = 7;
    localparam int GH  = 7;
    localparam int HLW = 3;

    typedef struct {
        longint sm;
        longint sh;
        longint mx;
        longint inv;
        longint at;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                  reset;
    logic                  start;
    logic                  abort;
    logic [EAW:0]          n_edge;
    logic [HLW-1:0]        hop_log2;

    logic                  re_edge, re_pos, busy, done;
    logic [EAW-1:0]        addr_edge;
    logic [NAW-1:0]        addr_pos;
    logic [NAW-1:0]        din_ea = '0, din_eb = '0;
    logic signed [CW-1:0]  din_px = '0, din_py = '0;
    logic [31:0]           sum_man, sum_hop, max_cost;
    logic [EAW:0]          invalid_cnt;

    logic                  d4_re_edge, d4_re_pos, d4_busy, d4_done;
    logic [EAW-1:0]        d4_addr_edge;
    logic [NAW-1:0]        d4_addr_pos;
    logic [NAW-1:0]        d4_din_ea = '0, d4_din_eb = '0;
    logic signed [CW-1:0]  d4_din_px = '0, d4_din_py = '0;
    logic [3:0]            d4_sum_man, d4_sum_hop, d4_max_cost;
    logic [EAW:0]          d4_invalid_cnt;

    logic [NAW-1:0]        mem_a [64];
    logic [NAW-1:0]        mem_b [64];
    logic signed [CW-1:0]  mem_x [64];
    logic signed [CW-1:0]  mem_y [64];

    exp_t   q[$];
    exp_t   q4[$];
    longint cyc = 0;
    int     compared = 0;
    int     mismatched = 0;

    placement_cost_eval #(
        .EDGE_AW(EAW), .NODE_AW(NAW), .COORD_W(CW), .GRID_W(GW), .GRID_H(GH),
        .ACC_W(32), .HOP_LW(HLW)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .n_edge(n_edge), .hop_log2(hop_log2),
        .re_edge(re_edge), .addr_edge(addr_edge), .din_ea(din_ea), .din_eb(din_eb),
        .re_pos(re_pos), .addr_pos(addr_pos), .din_px(din_px), .din_py(din_py),
        .busy(busy), .done(done), .sum_man(sum_man), .sum_hop(sum_hop),
        .max_cost(max_cost), .invalid_cnt(invalid_cnt)
    );

    placement_cost_eval #(
        .EDGE_AW(EAW), .NODE_AW(NAW), .COORD_W(CW), .GRID_W(GW), .GRID_H(GH),
        .ACC_W(4), .HOP_LW(HLW)
    ) dut4 (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .n_edge(n_edge), .hop_log2(hop_log2),
        .re_edge(d4_re_edge), .addr_edge(d4_addr_edge), .din_ea(d4_din_ea), .din_eb(d4_din_eb),
        .re_pos(d4_re_pos), .addr_pos(d4_addr_pos), .din_px(d4_din_px), .din_py(d4_din_py),
        .busy(d4_busy), .done(d4_done), .sum_man(d4_sum_man), .sum_hop(d4_sum_hop),
        .max_cost(d4_max_cost), .invalid_cnt(d4_invalid_cnt)
    );

    // Synchronous-read memories, one private read path per instance.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (re_edge) begin
            din_ea <= mem_a[addr_edge];
            din_eb <= mem_b[addr_edge];
        end
        if (re_pos) begin
            din_px <= mem_x[addr_pos];
            din_py <= mem_y[addr_pos];
        end
        if (d4_re_edge) begin
            d4_din_ea <= mem_a[d4_addr_edge];
            d4_din_eb <= mem_b[d4_addr_edge];
        end
        if (d4_re_pos) begin
            d4_din_px <= mem_x[d4_addr_pos];
            d4_din_py <= mem_y[d4_addr_pos];
        end
    end

    task automatic checkOutput(input string name, input longint act, input longint exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic failNow(input string name);
        compared++;
        mismatched++;
        $display("[TB] FAIL %s (t=%0t)", name, $time);
    endtask

    // Reference cost of the first n edges, evaluated straight from the
    // cost rules with integer arithmetic and clamping at 2^w-1.
    function automatic void refModel(input int n, input int k, input int w,
                                     output longint sm, output longint sh,
                                     output longint mx, output longint inv);
        longint lim = (longint'(1) << w) - 1;
        longint p = longint'(1) << k;
        sm = 0; sh = 0; mx = 0; inv = 0;
        for (int e = 0; e < n; e++) begin
            int ax = int'(mem_x[mem_a[e]]);
            int ay = int'(mem_y[mem_a[e]]);
            int bx = int'(mem_x[mem_b[e]]);
            int by = int'(mem_y[mem_b[e]]);
            bit bad = 0;
            longint dx, dy, cm, ch;
            if (ax == -1 || ay == -1 || bx == -1 || by == -1) bad = 1;
            if (ax < 0 || ax >= GW || ay < 0 || ay >= GH) bad = 1;
            if (bx < 0 || bx >= GW || by < 0 || by >= GH) bad = 1;
            if (ax == bx && ay == by) bad = 1;
            if (bad) begin
                inv++;
            end else begin
                dx = (ax > bx) ? ax - bx : bx - ax;
                dy = (ay > by) ? ay - by : by - ay;
                cm = dx + dy - 1;
                ch = (dx + p - 1) / p + (dy + p - 1) / p - 1;
                sm = (sm + cm > lim) ? lim : sm + cm;
                sh = (sh + ch > lim) ? lim : sh + ch;
                if (((cm > lim) ? lim : cm) > mx) mx = (cm > lim) ? lim : cm;
            end
        end
    endfunction

    task automatic setNode(input int nd, input int x, input int y);
        mem_x[nd] = CW'(x);
        mem_y[nd] = CW'(y);
    endtask

    task automatic setEdge(input int e, input int a, input int b);
        mem_a[e] = NAW'(a);
        mem_b[e] = NAW'(b);
    endtask

    task automatic loadBasic();
        setNode(10, 0, 0); setNode(11, 3, 0);
        setNode(12, 1, 1); setNode(13, 1, 5);
        setNode(14, 2, 2); setNode(15, 6, 6);
        setEdge(0, 10, 11); setEdge(1, 12, 13); setEdge(2, 14, 15);
    endtask

    // Monitor: every done pulse must match the oldest queued expectation,
    // including the cycle in which it arrives.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset && done) begin
                if (q.size() == 0) begin
                    failNow("unexpected_done");
                end else begin
                    e = q.pop_front();
                    checkOutput("sum_man", sum_man, e.sm);
                    checkOutput("sum_hop", sum_hop, e.sh);
                    checkOutput("max_cost", max_cost, e.mx);
                    checkOutput("invalid_cnt", invalid_cnt, e.inv);
                    checkOutput("done_cycle", cyc, e.at);
                    checkOutput("busy_at_done", busy, 1);
                end
            end
            if (reset && d4_done) begin
                if (q4.size() == 0) begin
                    failNow("unexpected_done_acc4");
                end else begin
                    e = q4.pop_front();
                    checkOutput("acc4_sum_man", d4_sum_man, e.sm);
                    checkOutput("acc4_sum_hop", d4_sum_hop, e.sh);
                    checkOutput("acc4_max_cost", d4_max_cost, e.mx);
                    checkOutput("acc4_invalid_cnt", d4_invalid_cnt, e.inv);
                    checkOutput("acc4_done_cycle", cyc, e.at);
                end
            end
        end
    end

    // One full run: queue the expectations, pulse start, optionally pulse
    // start again mid-run, and wait (bounded) for the done pulse.
    task automatic applyStimulus(input int n, input int k, input bit mid_start);
        exp_t e, e4;
        bit   seen = 0;
        @(negedge clk);
        refModel(n, k, 32, e.sm, e.sh, e.mx, e.inv);
        refModel(n, k, 4, e4.sm, e4.sh, e4.mx, e4.inv);
        e.at  = cyc + 9 * n + 1;
        e4.at = e.at;
        q.push_back(e);
        q4.push_back(e4);
        n_edge   = (EAW+1)'(n);
        hop_log2 = HLW'(k);
        start    = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        n_edge = (EAW+1)'($urandom_range(0, 9));
        checkOutput("busy_cycle1", busy, 1);
        for (int t = 1; t < 9 * n + 30; t++) begin
            if (done) begin
                seen = 1;
                break;
            end
            start = (mid_start && t == 5) ? 1'b1 : 1'b0;
            @(negedge clk);
        end
        start = 1'b0;
        if (!seen) begin
            failNow("done_timeout");
            q.delete();
            q4.delete();
        end
        @(negedge clk);
        checkOutput("busy_after_done", busy, 0);
    endtask

    initial begin
        reset    = 1'b0;
        start    = 1'b0;
        abort    = 1'b0;
        n_edge   = '0;
        hop_log2 = '0;
        for (int i = 0; i < 64; i++) begin
            setNode(i, 0, 0);
            setEdge(i, 0, 0);
        end
        repeat (3) @(negedge clk);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_done", done, 0);
        checkOutput("reset_re_edge", re_edge, 0);
        checkOutput("reset_re_pos", re_pos, 0);
        checkOutput("reset_sum_man", sum_man, 0);
        checkOutput("reset_sum_hop", sum_hop, 0);
        checkOutput("reset_max_cost", max_cost, 0);
        checkOutput("reset_invalid_cnt", invalid_cnt, 0);
        reset = 1'b1;

        $display("[TB] directed runs");
        loadBasic();
        applyStimulus(3, 1, 0);
        applyStimulus(3, 0, 0);
        applyStimulus(3, 2, 1);

        setNode(20, -1, -1); setNode(21, 2, 2);
        setNode(22, GW, 0);  setNode(23, 1, 1);
        setNode(24, 3, 3);
        setEdge(0, 20, 21); setEdge(1, 22, 23); setEdge(2, 24, 24);
        applyStimulus(3, 1, 0);
        applyStimulus(0, 0, 0);

        setNode(30, 0, 0); setNode(31, 4, 4); setNode(32, 5, 5);
        setEdge(0, 30, 31); setEdge(1, 30, 32);
        applyStimulus(2, 0, 0);

        $display("[TB] abort at cycle 12");
        loadBasic();
        begin
            longint base;
            @(negedge clk);
            base = cyc;
            n_edge = 3; hop_log2 = 1; start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            while (cyc - base < 12) @(negedge clk);
            abort = 1'b1;
            @(negedge clk);
            abort = 1'b0;
            checkOutput("abort_busy", busy, 0);
            checkOutput("abort_sum_man", sum_man, 2);
            checkOutput("abort_sum_hop", sum_hop, 1);
            checkOutput("abort_max_cost", max_cost, 2);
            checkOutput("abort_invalid_cnt", invalid_cnt, 0);
            checkOutput("abort_acc4_sum_man", d4_sum_man, 2);
            repeat (40) @(negedge clk);

            $display("[TB] reset at cycle 5");
            base = cyc;
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            while (cyc - base < 5) @(negedge clk);
            reset = 1'b0;
            @(negedge clk);
            reset = 1'b1;
            checkOutput("midreset_busy", busy, 0);
            checkOutput("midreset_re_pos", re_pos, 0);
            checkOutput("midreset_addr_pos", addr_pos, 0);
            checkOutput("midreset_addr_edge", addr_edge, 0);
            checkOutput("midreset_sum_man", sum_man, 0);
            checkOutput("midreset_invalid_cnt", invalid_cnt, 0);
            repeat (40) @(negedge clk);
        end

        $display("[TB] random runs");
        for (int r = 0; r < 20; r++) begin
            for (int i = 0; i < 64; i++) begin
                setNode(i, int'($urandom_range(0, 9)) - 1, int'($urandom_range(0, 9)) - 1);
                setEdge(i, int'($urandom_range(0, 63)), int'($urandom_range(0, 63)));
            end
            applyStimulus(int'($urandom_range(0, 12)), int'($urandom_range(0, 7)),
                          bit'($urandom_range(0, 1)));
        end

        repeat (5) @(negedge clk);
        if (q.size() != 0 || q4.size() != 0) failNow("scoreboard_not_empty");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/placement_cost_eval.md
# placement_cost_eval

Parametrised wire-cost evaluator for the placement flow. Walks an edge list (endpoint memories A/B) and the node position memories (X/Y), and accumulates Manhattan cost, k-hop cost (hop length 2^k, runtime-selectable), and worst-edge cost. It replaces the hard-wired single-grid, 1-hop evaluation tail of the placer. It runs after placement completes, started by the placer FSM or the testbench.

## Interface
Parameters:
- `EDGE_AW`, 6: edge-memory address width (max 2^EDGE_AW edges)
- `NODE_AW`, 6: node/position-memory address width
- `COORD_W`, 16: signed coordinate width; -1 = unplaced
- `GRID_W`, 7: grid columns; valid x is 0..GRID_W-1
- `GRID_H`, 7: grid rows; valid y is 0..GRID_H-1
- `ACC_W`, 32: accumulator width
- `HOP_LW`, 3: width of hop_log2

Ports:
- `clk` in 1: clock
- `reset` in 1: synchronous, active-low (reset when 0)
- `start` in 1: single-cycle request; sampled only in IDLE
- `abort` in 1: return to IDLE; no `done`
- `n_edge` in EDGE_AW+1: edges to evaluate; latched at start
- `hop_log2` in HOP_LW: hop length = 2^hop_log2; latched at start
- `re_edge` out 1, `addr_edge` out EDGE_AW: shared read for A and B edge ROMs
- `din_ea`, `din_eb` in NODE_AW: edge endpoints
- `re_pos` out 1, `addr_pos` out NODE_AW: shared read for X and Y position RAMs
- `din_px`, `din_py` in COORD_W signed: node coordinates
- `busy` out 1; `done` out 1: one-cycle pulse
- `sum_man`, `sum_hop`, `max_cost` out ACC_W: results
- `invalid_cnt` out EDGE_AW+1: edges excluded from cost

## Operation
- Memories use the codebase ROM/RAM read protocol. `re`/`addr` are registered outputs. The block captures data in the second state after the issuing state.
- States: IDLE, E_RD, E_WT, A_RD, A_WT, B_RD, B_WT, B_CAP, DIFF, ACC, DONE.
- IDLE & start:
  - Clear all results.
  - Latch `n_edge` and `hop_log2`; set i=0.
  - Go to DONE if n_edge==0, else E_RD.
- E_RD: issue edge read at i. A_RD captures a/b and issues position read at a. B_RD captures ax/ay and issues read at b. B_CAP captures bx/by.
- DIFF computes dx=|ax-bx| and dy=|ay-by| at COORD_W+1 bits, and the validity flag.
- An edge is invalid if any coordinate is -1, any coordinate is outside the grid, or (ax,ay)==(bx,by).
- ACC, invalid edge: `invalid_cnt`+1; sums unchanged.
- ACC, valid edge:
  - c_man = dx+dy-1
  - c_hop = ceil(dx/2^k)+ceil(dy/2^k)-1, where ceil(d/2^k) = (d+2^k-1)>>k
  - `sum_man`+=c_man, `sum_hop`+=c_hop, `max_cost`=max(max_cost,c_man)
- All sums saturate at 2^ACC_W-1; they never wrap.
- After ACC: i+1. Go to DONE when i+1==n_edge, else E_RD.
- DONE: `done`=1 for one cycle, then IDLE. Results hold until the next accepted start.
- `start` while busy: ignored.
- `abort` in any non-IDLE state: next state IDLE, `done` not pulsed, results hold their partial values. `abort` has priority over `start`.
- hop_log2=0: `sum_hop` equals `sum_man`.

## Timing
- Reset (reset==0): state IDLE; `busy`, `done`, `re_edge`, `re_pos`, addresses, `sum_man`, `sum_hop`, `max_cost`, `invalid_cnt` all 0.
- Exactly 9 cycles per edge.
- Start accepted at cycle 0 gives `done` high in cycle 9·n_edge+1. n_edge=0 gives `done` in cycle 1.
- `busy` is high from cycle 1 until the DONE cycle inclusive.
- Reset mid-run overrides everything in the same cycle.

## Structure
- `placement_pkg`: state enum, `NO_POS` (-1), `sat_add` function, grid-bounds check function. Shared with the placer.
- Sub-module `hop_cost`: registered DIFF→ACC datapath taking (ax,ay,bx,by,hop_log2) and producing (valid, c_man, c_hop). The FSM, address generation and accumulators stay in `placement_cost_eval`.

## Test plan
- 3 edges with positions (0,0)-(3,0), (1,1)-(1,5), (2,2)-(6,6), hop_log2=1 -> sum_man=2+3+7=12, sum_hop=1+1+3=5, max_cost=7, invalid_cnt=0, done at cycle 28.
- Same set, hop_log2=0 -> sum_hop=12; hop_log2=2 -> sum_hop=0+0+1=1.
- Edge with an endpoint at (-1,-1), edge with x=GRID_W, and edge with coincident endpoints -> invalid_cnt=3, sums 0.
- n_edge=0 -> done in cycle 1, all results 0. `start` pulsed mid-run -> ignored, done timing unchanged.
- `abort` at cycle 12 of a 3-edge run -> IDLE next cycle, no done, sum_man=2. `reset`=0 at cycle 5 -> all outputs 0.
- ACC_W=4 with edges of cost 7 and 9 -> sum_man saturates at 15.
